// File: rtl/swin_rd_seq.sv
// Raster read sequencer for the 16-bank pixel-interleaved frame store.
// Issues one broadcast word read per accepted pixel and tracks the tag through the 2-cycle read/mux path.
module swin_rd_seq #(
  parameter int IMG_W  = 64,
  parameter int IMG_H  = 16,
  parameter int X_W    = 6,
  parameter int Y_W    = 4,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              pix_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [3:0]        sel_o,
  output logic              pix_valid_o,
  output logic              pix_last_o,
  output logic [X_W-1:0]    pix_x_o,
  output logic [Y_W-1:0]    pix_y_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [X_W-1:0] XMAX = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] YMAX = Y_W'(IMG_H - 1);

  state_t              state_q;
  logic [X_W-1:0]      x_q, s1_x_q, px_q;
  logic [Y_W-1:0]      y_q, s1_y_q, py_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          sel_q;
  logic                s1_last_q, pl_q, done_q;
  logic [2:1]          vld_pipe_q;
  logic                issue, eol, eof;

  assign issue = (state_q == RUN) && pix_ready_i;
  assign eol   = (x_q == XMAX);
  assign eof   = eol && (y_q == YMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      addr_q     <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_last_q  <= 1'b0;
      sel_q      <= '0;
      vld_pipe_q <= '0;
      pl_q       <= 1'b0;
      px_q       <= '0;
      py_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= RUN;
          x_q     <= '0;
          y_q     <= '0;
          addr_q  <= '0;
        end
        RUN: if (issue) begin
          x_q <= eol ? '0 : x_q + X_W'(1);
          // One BRAM word holds 16 adjacent pixels; rows stay contiguous since IMG_W%16==0
          if (x_q[3:0] == 4'hF) addr_q <= addr_q + ADDR_W'(1);
          if (eol) y_q <= y_q + Y_W'(1);
          if (eof) state_q <= DRAIN;
        end
        DRAIN: if (pl_q) begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Stage 1 lines up with BRAM data (drives the mux select), stage 2 with the mux output
      vld_pipe_q <= {vld_pipe_q[1], issue};
      if (issue) begin
        s1_x_q    <= x_q;
        s1_y_q    <= y_q;
        s1_last_q <= eof;
        sel_q     <= x_q[3:0];
      end
      pl_q <= vld_pipe_q[1] && s1_last_q;
      if (vld_pipe_q[1]) begin
        px_q <= s1_x_q;
        py_q <= s1_y_q;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign rd_en_o     = issue;
  assign rd_addr_o   = addr_q;
  assign sel_o       = sel_q;
  assign pix_valid_o = vld_pipe_q[2];
  assign pix_last_o  = pl_q;
  assign pix_x_o     = px_q;
  assign pix_y_o     = py_q;

endmodule

// File: tb/tb_swin_rd_seq.sv
// Directed bench for swin_rd_seq: raster scoreboard of expected pixel tags plus issue/latency monitors.
module tb_swin_rd_seq;
  logic       clk = 1'b0, rst_n = 1'b0, start_i = 1'b0, pix_ready_i = 1'b0;
  logic       busy_o, done_o, rd_en_o, pix_valid_o, pix_last_o;
  logic [5:0] rd_addr_o, pix_x_o;
  logic [3:0] sel_o, pix_y_o;

  swin_rd_seq #(.IMG_W(64), .IMG_H(16), .X_W(6), .Y_W(4), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .pix_ready_i(pix_ready_i),
    .busy_o(busy_o), .done_o(done_o), .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o),
    .sel_o(sel_o), .pix_valid_o(pix_valid_o), .pix_last_o(pix_last_o),
    .pix_x_o(pix_x_o), .pix_y_o(pix_y_o)
  );

  always #5 clk = ~clk;

  int          nchk = 0, nfail = 0;
  logic [10:0] exp_q[$];
  logic [10:0] e;
  int          iss_cnt = 0, pv_cnt = 0, done_cnt = 0, cyc = 0, last_rd_cyc = 0;
  int          lowrun_v = 0, max_lowrun = 0, bad_rd = 0;
  logic        prev_iss = 1'b0, rdy_prev = 1'b0;
  logic [3:0]  sel_exp = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [24:0] all_outs();
    return {busy_o, done_o, rd_en_o, rd_addr_o, sel_o, pix_valid_o, pix_last_o, pix_x_o, pix_y_o};
  endfunction

  // Issue, select and output-side monitor, sampled mid-cycle
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_iss = 1'b0;
      rdy_prev = 1'b0;
      lowrun_v = 0;
    end else begin
      if (prev_iss) chk("sel", 32'(sel_o), 32'(sel_exp));
      prev_iss = rd_en_o;
      if (rd_en_o) begin
        if (!pix_ready_i) bad_rd++;
        chk("rd_addr", 32'(rd_addr_o), 32'((iss_cnt / 16) % 64));
        sel_exp     = 4'(iss_cnt % 16);
        iss_cnt++;
        last_rd_cyc = cyc;
      end
      if (!pix_ready_i) begin
        if (rdy_prev) lowrun_v = 0;
        if (pix_valid_o) lowrun_v++;
        if (lowrun_v > max_lowrun) max_lowrun = lowrun_v;
      end
      rdy_prev = pix_ready_i;
      if (pix_valid_o) begin
        if (exp_q.size() == 0) chk("pix_extra", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("pix_tag", 32'({pix_x_o, pix_y_o, pix_last_o}), 32'(e));
        end
        pv_cnt++;
      end
      if (done_o) begin
        done_cnt++;
        chk("done_lat", 32'(cyc - last_rd_cyc), 32'd3);
      end
    end
  end

  task automatic new_frame();
    exp_q.delete();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 64; x++)
        exp_q.push_back({6'(x), 4'(y), (x == 63 && y == 15)});
    iss_cnt = 0; pv_cnt = 0; done_cnt = 0; max_lowrun = 0; bad_rd = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n = 0;
    bit hit = 1'b0;
    while (n < budget && !hit) begin
      @(posedge clk); #1;
      if (rnd) pix_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (done_o) hit = 1'b1;
      n++;
    end
    #1;
    if (!hit) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic frame_end(input bit linger);
    chk("busy_at_done", 32'(busy_o), 32'd0);
    if (linger) repeat (5) @(negedge clk);
    #1;
    chk("iss_cnt", 32'(iss_cnt), 32'd1024);
    chk("pv_cnt", 32'(pv_cnt), 32'd1024);
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    chk("done_cnt", 32'(done_cnt), 32'd1);
  endtask

  initial begin
    int n;
    // Reset and idle
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'(all_outs()), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1; pix_ready_i = 1'b1;
    @(negedge clk);
    chk("idle_outs", 32'(all_outs()), 32'd0);
    n = 0;
    repeat (50) begin @(negedge clk); if (rd_en_o) n++; end
    chk("idle_no_rd", 32'(n), 32'd0);

    // Full-rate frame
    new_frame();
    pulse_start();
    wait_done(1200, 1'b0);
    frame_end(1'b1);

    // Random backpressure
    new_frame();
    pulse_start();
    wait_done(6000, 1'b1);
    pix_ready_i = 1'b1;
    frame_end(1'b1);
    chk("bp_inflight_le2", 32'(max_lowrun <= 2), 32'd1);
    chk("bp_rd_while_low", 32'(bad_rd), 32'd0);

    // Start ignored in RUN and DRAIN
    new_frame();
    pulse_start();
    repeat (500) @(posedge clk);
    pulse_start();
    n = 0;
    while (iss_cnt < 1024 && n < 1200) begin @(negedge clk); #1; n++; end
    chk("reach_last_issue", 32'(iss_cnt), 32'd1024);
    pulse_start();
    wait_done(20, 1'b0);
    frame_end(1'b1);

    // Reset mid-frame at pixel 300
    new_frame();
    pulse_start();
    n = 0;
    while (pv_cnt < 300 && n < 1200) begin @(negedge clk); #1; n++; end
    chk("reach_px300", 32'(pv_cnt), 32'd300);
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outs", 32'(all_outs()), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    new_frame();
    repeat (20) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_no_rd", 32'(iss_cnt), 32'd0);
    pulse_start();
    wait_done(1200, 1'b0);
    frame_end(1'b1);

    // Back-to-back: start raised in the done cycle
    new_frame();
    pulse_start();
    wait_done(1200, 1'b0);
    chk("b2b_f1_iss", 32'(iss_cnt), 32'd1024);
    chk("b2b_f1_q", 32'(exp_q.size()), 32'd0);
    new_frame();
    start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("b2b_rd_en", 32'(rd_en_o), 32'd1);
    chk("b2b_addr0", 32'(rd_addr_o), 32'd0);
    wait_done(1200, 1'b0);
    frame_end(1'b1);

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end
endmodule
